// File: rtl/memory_arbiter.sv
// Two-requester (CPU / IOP) arbiter for a single word-addressed memory port.
// One access in flight at a time; a watchdog aborts accesses that never see mem_ready.
module memory_arbiter #(
  parameter int IOP_PRIORITY = 1,
  parameter int TIMEOUT      = 15
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cpu_req,
  input  logic [15:31] cpu_addr,
  input  logic         cpu_we,
  input  logic [0:31]  cpu_wdata,
  output logic         cpu_gnt,
  output logic         cpu_done,
  input  logic         iop_req,
  input  logic [15:31] iop_addr,
  input  logic         iop_we,
  input  logic [0:31]  iop_wdata,
  output logic         iop_gnt,
  output logic         iop_done,
  output logic [0:31]  rdata,
  output logic         err,
  output logic         mem_req,
  output logic [15:31] mem_addr,
  output logic         mem_we,
  output logic [0:31]  mem_wdata,
  input  logic [0:31]  mem_rdata,
  input  logic         mem_ready
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         last_iop_q, last_iop_d;
  logic         owner_iop_q, owner_iop_d;
  logic         mem_req_q, mem_req_d;
  logic [15:31] mem_addr_q, mem_addr_d;
  logic         mem_we_q, mem_we_d;
  logic [0:31]  mem_wdata_q, mem_wdata_d;
  logic [0:31]  rdata_q, rdata_d;
  logic         cpu_gnt_q, cpu_gnt_d, iop_gnt_q, iop_gnt_d;
  logic         cpu_done_q, cpu_done_d, iop_done_q, iop_done_d;
  logic         err_q, err_d;
  logic         pick_iop;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_iop_d  = last_iop_q;
    owner_iop_d = owner_iop_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    cpu_gnt_d   = 1'b0;
    iop_gnt_d   = 1'b0;
    cpu_done_d  = 1'b0;
    iop_done_d  = 1'b0;
    err_d       = 1'b0;
    // A lone requester always wins; ties follow the priority mode.
    pick_iop    = iop_req && (!cpu_req || (IOP_PRIORITY != 0) || !last_iop_q);

    case (state_q)
      IDLE: begin
        if (cpu_req || iop_req) begin
          mem_addr_d  = pick_iop ? iop_addr  : cpu_addr;
          mem_we_d    = pick_iop ? iop_we    : cpu_we;
          mem_wdata_d = pick_iop ? iop_wdata : cpu_wdata;
          mem_req_d   = 1'b1;
          cpu_gnt_d   = !pick_iop;
          iop_gnt_d   = pick_iop;
          owner_iop_d = pick_iop;
          last_iop_d  = pick_iop;
          cnt_d       = 8'd0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          rdata_d    = mem_we_q ? '0 : mem_rdata;
          cpu_done_d = !owner_iop_q;
          iop_done_d = owner_iop_q;
          mem_req_d  = 1'b0;
          state_d    = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Watchdog expiry: finish the access as an error with no data.
          rdata_d    = '0;
          err_d      = 1'b1;
          cpu_done_d = !owner_iop_q;
          iop_done_d = owner_iop_q;
          mem_req_d  = 1'b0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      last_iop_q  <= 1'b1;
      owner_iop_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      cpu_gnt_q   <= 1'b0;
      iop_gnt_q   <= 1'b0;
      cpu_done_q  <= 1'b0;
      iop_done_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_iop_q  <= last_iop_d;
      owner_iop_q <= owner_iop_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      cpu_gnt_q   <= cpu_gnt_d;
      iop_gnt_q   <= iop_gnt_d;
      cpu_done_q  <= cpu_done_d;
      iop_done_q  <= iop_done_d;
      err_q       <= err_d;
    end
  end

  assign cpu_gnt   = cpu_gnt_q;
  assign iop_gnt   = iop_gnt_q;
  assign cpu_done  = cpu_done_q;
  assign iop_done  = iop_done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
Two-port memory arbiter between the microcoded CPU and the I/O processor (DMA). Both requesters share a single 17-bit word-addressed, 32-bit-data memory port. The arbiter selects one requester, registers its address, write enable and data, drives the memory port until ready, and returns the read data and a completion strobe. A watchdog aborts accesses to non-responding memory.

Parameters:
IOP_PRIORITY, 1, 1 = IOP always wins a simultaneous request; 0 = round-robin by last winner
TIMEOUT, 15, maximum BUSY cycles without mem_ready before abort (1..255)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
cpu_req  input  1  CPU access request, level
cpu_addr  input  [15:31]  CPU word address
cpu_we  input  1  CPU write enable
cpu_wdata  input  [0:31]  CPU write data
cpu_gnt  output  1  one-cycle pulse: CPU request accepted
cpu_done  output  1  one-cycle pulse: CPU access complete
iop_req / iop_addr / iop_we / iop_wdata  input  1/[15:31]/1/[0:31]  IOP request, same semantics as CPU
iop_gnt / iop_done  output  1/1  IOP accept and complete pulses
rdata  output  [0:31]  read data, valid in the done cycle
err  output  1  valid with done: 1 = timeout abort
mem_req  output  1  memory access active
mem_addr  output  [15:31]  registered address
mem_we  output  1  registered write enable
mem_wdata  output  [0:31]  registered write data
mem_rdata  input  [0:31]  memory read data
mem_ready  input  1  memory completes the access this cycle

Behaviour:
- States: IDLE, BUSY. Reset (reset=0, asynchronous) forces IDLE, all outputs 0, watchdog counter 0, and the round-robin pointer to "CPU next". Reset in BUSY abandons the access with no done pulse.
- IDLE: requests are sampled at the rising edge.
  - If neither request is asserted, remain in IDLE.
  - Otherwise select the winner. With IOP_PRIORITY=1 the IOP wins ties. With IOP_PRIORITY=0 ties go to the requester that did not win last; a lone requester always wins.
  - At the edge: latch the winner's addr/we/wdata into mem_addr/mem_we/mem_wdata, set mem_req=1, pulse the winner's gnt in the following cycle, set the counter to 0, and enter BUSY.
- BUSY: mem_req=1; memory outputs hold stable; requests are ignored.
  - mem_ready=1: capture mem_rdata into rdata (0 for writes), pulse the winner's done with err=0, set mem_req=0, go to IDLE, update the round-robin pointer.
  - mem_ready=0: increment the counter. When the counter reaches TIMEOUT-1 without ready, pulse done with err=1, rdata=0, mem_req=0, go to IDLE.
  - mem_ready in the same cycle as the timeout: ready wins, err=0.
- Latency: request sampled at edge N; gnt and mem_req high in cycle N+1. Earliest ready is sampled at edge N+2, so done is high in cycle N+2. The next arbitration samples at edge N+2, so back-to-back accesses run every 2 cycles minimum.
- A requester holds addr/we/wdata stable until its gnt pulse. A req still high in IDLE after done starts a new access.
- gnt, done and err are registered single-cycle pulses. At most one gnt and one done are high per cycle. rdata holds its value until the next done.
- mem_ready outside BUSY is ignored.
- The counter is wide enough for TIMEOUT: 8 bits.

Test Plan:
- Reset released; cpu_req=1, addr=17'h00100, we=0; mem_ready 2 cycles after mem_req, mem_rdata=32'h0A0B0C0D -> cpu_gnt one cycle after req sample, mem_addr=17'h00100, cpu_done with rdata=32'h0A0B0C0D, err=0, iop_done never high.
- IOP_PRIORITY=1, cpu_req and iop_req both held high, ready immediate -> grants alternate never; IOP wins every arbitration, one access per 2 cycles, CPU starves.
- IOP_PRIORITY=0, both held high, ready immediate -> gnt order CPU, IOP, CPU, IOP; each done precedes the next gnt.
- IOP write addr=17'h1FFFF, wdata=32'hFFFFFFFF, mem_ready never -> mem_req high exactly TIMEOUT cycles, iop_done with err=1, rdata=0, then IDLE; subsequent CPU read completes normally with err=0.
- reset driven low mid-BUSY between clock edges -> mem_req, gnt, done and err go 0 immediately without a clock; after release, the first tied request with IOP_PRIORITY=0 goes to the CPU.
